// File: rtl/wb_arbiter_pkg.sv
// Shared writeback types: register-file bus widths, reset constants,
// arbiter state encoding and the grant-source flag values.
package wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic [REG_DATA_W-1:0] Zero     = '0;
    localparam logic                  Enabled  = 1'b1;
    localparam logic                  Disabled = 1'b0;

    typedef enum logic {
        ST_PRI_LSU   = 1'b0,
        ST_FORCE_ALU = 1'b1
    } wb_state_e;

    localparam logic WB_SRC_ALU = 1'b0;
    localparam logic WB_SRC_LSU = 1'b1;

endpackage

// File: rtl/wb_arbiter.sv
// Two-requester writeback arbiter onto the single regfile write port: LSU wins
// conflicts unless the ALU has lost MAX_WAIT in a row; the winner is written one cycle later.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 3,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_waddr,
    input  logic [REG_DATA_W-1:0] alu_wdata,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_waddr,
    input  logic [REG_DATA_W-1:0] lsu_wdata,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [REG_DATA_W-1:0] rf_wdata,
    output logic                  grant_lsu
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    wb_state_e             state_q, state_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [REG_DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic                  grant_lsu_q, grant_lsu_d;
    logic                  alu_win, lsu_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_PRI_LSU;
            wait_cnt_q  <= '0;
            rf_we_q     <= Disabled;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= Zero;
            grant_lsu_q <= WB_SRC_ALU;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            grant_lsu_q <= grant_lsu_d;
        end
    end

    always_comb begin
        alu_win     = 1'b0;
        lsu_win     = 1'b0;
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        rf_we_d     = Disabled;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        grant_lsu_d = grant_lsu_q;

        if (!rst) begin
            if (alu_valid && (!lsu_valid || state_q == ST_FORCE_ALU)) begin
                alu_win = 1'b1;
            end else if (lsu_valid) begin
                lsu_win = 1'b1;
            end
        end

        // Only a lost conflict counts against the ALU; saturate at the force threshold.
        if (alu_win) begin
            wait_cnt_d = '0;
        end else if (lsu_win && alu_valid && wait_cnt_q != MAX_CNT) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        case (state_q)
            ST_PRI_LSU:   if (wait_cnt_d == MAX_CNT) state_d = ST_FORCE_ALU;
            ST_FORCE_ALU: if (alu_win) state_d = ST_PRI_LSU;
            default:      state_d = ST_PRI_LSU;
        endcase

        // x0 destinations are consumed but leave the write port untouched.
        if (alu_win && alu_waddr != '0) begin
            rf_we_d     = Enabled;
            rf_waddr_d  = alu_waddr;
            rf_wdata_d  = alu_wdata;
            grant_lsu_d = WB_SRC_ALU;
        end else if (lsu_win && lsu_waddr != '0) begin
            rf_we_d     = Enabled;
            rf_waddr_d  = lsu_waddr;
            rf_wdata_d  = lsu_wdata;
            grant_lsu_d = WB_SRC_LSU;
        end
    end

    assign alu_ready = alu_win;
    assign lsu_ready = lsu_win;
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign grant_lsu = grant_lsu_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: fixed vectors with hand-computed grants and writes.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_waddr;
    logic [31:0] lsu_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        grant_lsu;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [4:0]  A_ADDR = 5'd1;
    localparam logic [31:0] A_DATA = 32'h0000_00A1;
    localparam logic [4:0]  L_ADDR = 5'd2;
    localparam logic [31:0] L_DATA = 32'h0000_00B2;

    always #5 clk = ~clk;

    wb_arbiter #(.MAX_WAIT(3), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_waddr (alu_waddr),
        .alu_wdata (alu_wdata),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_waddr (lsu_waddr),
        .lsu_wdata (lsu_wdata),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .grant_lsu (grant_lsu)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        alu_valid = av; alu_waddr = aa; alu_wdata = ad;
        lsu_valid = lv; lsu_waddr = la; lsu_wdata = ld;
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic step(input string tag, input logic exp_ar, input logic exp_lr,
                        input logic exp_we, input logic [4:0] exp_a,
                        input logic [31:0] exp_d, input logic exp_gl);
        #3;
        chk({tag, ".alu_ready"}, 32'(alu_ready), 32'(exp_ar));
        chk({tag, ".lsu_ready"}, 32'(lsu_ready), 32'(exp_lr));
        @(posedge clk);
        #1;
        chk({tag, ".rf_we"},     32'(rf_we),     32'(exp_we));
        chk({tag, ".rf_waddr"},  32'(rf_waddr),  32'(exp_a));
        chk({tag, ".rf_wdata"},  rf_wdata,       exp_d);
        chk({tag, ".grant_lsu"}, 32'(grant_lsu), 32'(exp_gl));
    endtask

    // Both requesters valid; exp_lsu selects which one must win.
    task automatic conflict(input string tag, input logic exp_lsu);
        drive(1'b1, A_ADDR, A_DATA, 1'b1, L_ADDR, L_DATA);
        if (exp_lsu) step(tag, 1'b0, 1'b1, 1'b1, L_ADDR, L_DATA, 1'b1);
        else         step(tag, 1'b1, 1'b0, 1'b1, A_ADDR, A_DATA, 1'b0);
    endtask

    logic [7:0] lsu_pattern;

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // Reset holds both readies low even with both valid.
        drive(1'b1, A_ADDR, A_DATA, 1'b1, L_ADDR, L_DATA);
        step("reset", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        rst = 1'b0;

        drive(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
        step("alu_only", 1'b1, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b0);

        // Starvation guard: LSU x3 then ALU, twice.
        lsu_pattern = 8'b0111_0111;
        for (int i = 0; i < 8; i++) begin
            conflict($sformatf("starve%0d", i), lsu_pattern[i]);
        end

        // x0 write: accepted but no regfile write; previous ALU write persists.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD_BEEF);
        step("x0", 1'b0, 1'b1, 1'b0, A_ADDR, A_DATA, 1'b0);

        // Same destination serialised: LSU first, then the held ALU request.
        drive(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
        step("same0", 1'b0, 1'b1, 1'b1, 5'd7, 32'hB, 1'b1);
        drive(1'b1, 5'd7, 32'hA, 1'b0, 5'd0, 32'd0);
        step("same1", 1'b1, 1'b0, 1'b1, 5'd7, 32'hA, 1'b0);

        // Two LSU wins, reset mid-run, then the counter must restart from zero.
        conflict("pre_rst0", 1'b1);
        conflict("pre_rst1", 1'b1);
        rst = 1'b1;
        drive(1'b1, A_ADDR, A_DATA, 1'b1, L_ADDR, L_DATA);
        step("mid_rst", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        rst = 1'b0;
        conflict("post_rst0", 1'b1);
        conflict("post_rst1", 1'b1);
        conflict("post_rst2", 1'b1);
        conflict("post_rst3", 1'b0);

        // Alternating single requests: each granted at once, counter never moves.
        for (int i = 0; i < 20; i++) begin
            logic [4:0]  a;
            logic [31:0] d;
            a = 5'(i + 3);
            d = 32'h5000_0000 + 32'(i);
            if (i % 2 == 0) begin
                drive(1'b1, a, d, 1'b0, 5'd0, 32'd0);
                step($sformatf("alt%0d", i), 1'b1, 1'b0, 1'b1, a, d, 1'b0);
            end else begin
                drive(1'b0, 5'd0, 32'd0, 1'b1, a, d);
                step($sformatf("alt%0d", i), 1'b0, 1'b1, 1'b1, a, d, 1'b1);
            end
            chk($sformatf("alt%0d.wait_cnt", i), 32'(dut.wait_cnt_q), 32'd0);
        end

        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step("idle", 1'b0, 1'b0, 1'b0, 5'd22, 32'h5000_0013, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
